// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - framed UART byte stream to instruction RAM word writer
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   RxValid, RxData   one-cycle byte strobe and byte from the UART receiver
//   WriteEnable       one-cycle instruction RAM write strobe
//   WriteAddress      byte address of the write (0x000..0x3FC)
//   WriteData         assembled big-endian instruction word
//   CpuHold           processor held in reset while high
//   Done, Error       result of the last load
//   LoadedWords       words written in the current or last load (0..256)
module imem_boot_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         TIMEOUT_WIDTH  = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RxValid,
  input  logic [7:0]  RxData,
  output logic        WriteEnable,
  output logic [31:0] WriteAddress,
  output logic [31:0] WriteData,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error,
  output logic [8:0]  LoadedWords
);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  // The gap counter reaching this value with no byte this cycle means the
  // limit is hit on the coming edge.
  localparam logic [TIMEOUT_WIDTH-1:0] GAP_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                   state, next_state;
  logic [8:0]               target;
  logic [1:0]               byte_cnt;
  logic [23:0]              asm_word;
  logic [7:0]               csum;
  logic [TIMEOUT_WIDTH-1:0] gap;
  logic [8:0]               loaded;
  logic                     we_q;
  logic [7:0]               addr_q;
  logic [31:0]              data_q;

  logic loading, start, word_done, last_word, timeout;

  assign loading   = (state == S_COUNT) || (state == S_DATA) || (state == S_CSUM);
  assign start     = RxValid && (RxData == SYNC_BYTE) &&
                     ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign word_done = (state == S_DATA) && RxValid && (byte_cnt == 2'd3);
  assign last_word = (loaded + 9'd1) == target;
  // An arriving byte always beats the timeout, hence the !RxValid term.
  assign timeout   = loading && !RxValid && (gap == GAP_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) next_state = S_COUNT;
      S_COUNT:               if (RxValid) next_state = S_DATA;
      S_DATA:                if (word_done && last_word) next_state = S_CSUM;
      S_CSUM:                if (RxValid) next_state = (RxData == csum) ? S_DONE : S_ERR;
      default:               next_state = S_IDLE;
    endcase
    if (timeout) next_state = S_ERR;
  end

  always_comb begin
    CpuHold = loading || (state == S_ERR);
    Done    = (state == S_DONE);
    Error   = (state == S_ERR);
  end

  // Datapath: assembler, checksum, gap counter and the write register.
  // The write register is loaded on the 4th byte so the assembler is free
  // to take the next byte during the WriteEnable cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      target   <= '0;
      byte_cnt <= '0;
      asm_word <= '0;
      csum     <= '0;
      gap      <= '0;
      loaded   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      we_q <= 1'b0;
      gap  <= (loading && !RxValid) ? gap + TIMEOUT_WIDTH'(1) : '0;
      if (start) begin
        loaded   <= '0;
        csum     <= '0;
        byte_cnt <= '0;
        asm_word <= '0;
      end
      if (state == S_COUNT && RxValid) begin
        target <= (RxData == 8'd0) ? 9'd256 : {1'b0, RxData};
      end
      if (state == S_DATA && RxValid) begin
        csum     <= csum ^ RxData;
        asm_word <= {asm_word[15:0], RxData};
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          we_q   <= 1'b1;
          addr_q <= loaded[7:0];
          data_q <= {asm_word, RxData};
          loaded <= loaded + 9'd1;
        end
      end
    end
  end

  assign WriteEnable  = we_q;
  assign WriteAddress = {22'd0, addr_q, 2'b00};
  assign WriteData    = data_q;
  assign LoadedWords  = loaded;

endmodule
